// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame states, limits and helpers
// Used by the transmit framer, the register file and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MAX_DATA   = 9;
  localparam int MIN_DATA   = 5;
  localparam int DEF_DATA   = 8;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Out-of-range lengths fall back to the default rather than erroring.
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    if (len >= 4'(MIN_DATA) && len <= 4'(MAX_DATA)) begin
      return len;
    end
    return 4'(DEF_DATA);
  endfunction

  function automatic logic [MAX_DATA-1:0] len_mask(input logic [3:0] len);
    logic [MAX_DATA-1:0] m;
    for (int i = 0; i < MAX_DATA; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_tx_framer_bit_timer.sv
// rtl/uart_tx_framer_bit_timer.sv - oversample tick counter with wrap pulse
// Counts 0..OVERSAMPLE-1 while enabled; o_wrap marks the last tick of a bit.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap
);

  localparam int W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [W-1:0] r_tick;
  logic         w_last;

  assign w_last = (r_tick == W'(OVERSAMPLE - 1));
  assign o_wrap = i_en && w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_tick <= '0;
    end else if (i_en) begin
      r_tick <= w_last ? '0 : r_tick + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - serialises one data word per start into a UART frame
// Frame settings are latched on acceptance so register writes never disturb a frame in flight.
module uart_tx_framer
  import uart_pkg::*;
(
  input  logic                clk_16bd,
  input  logic                rst,
  input  logic                tx_start,
  input  logic [MAX_DATA-1:0] tx_data,
  input  logic                parity,
  input  logic                parity_type,
  input  logic                stop_bits,
  input  logic [3:0]          frame_length,
  output logic                tx,
  output logic                tx_ready,
  output logic                tx_done
);

  uart_state_e         r_state;
  uart_state_e         w_state_nxt;
  logic [MAX_DATA-1:0] r_shift;
  logic [3:0]          r_len;
  logic [3:0]          r_bit_idx;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_stop2;
  logic                r_stop_cnt;
  logic                r_tx;
  logic                r_done;

  logic                w_wrap;
  logic                w_accept;
  logic                w_shift_en;
  logic                w_stop_inc;
  logic                w_tx_nxt;
  logic                w_done_nxt;
  logic [3:0]          w_eff_len;
  logic [MAX_DATA-1:0] w_data_masked;
  logic                w_par;

  assign w_eff_len     = eff_len(frame_length);
  assign w_data_masked = tx_data & len_mask(w_eff_len);
  assign w_par         = (^w_data_masked) ^ (parity_type == ODD);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .i_clk (clk_16bd),
    .i_rst (rst),
    .i_clr (w_accept),
    .i_en  (r_state != IDLE),
    .o_wrap(w_wrap)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (tx_start) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_wrap) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_wrap) begin
          if (r_bit_idx == r_len - 4'd1) begin
            w_state_nxt = r_par_en ? PARITY : STOP;
            w_tx_nxt    = r_par_en ? r_par_bit : 1'b1;
          end else begin
            // Data leaves LSB first; the next bit is already at position 1.
            w_shift_en = 1'b1;
            w_tx_nxt   = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (w_wrap) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (w_wrap) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_inc = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_len      <= '0;
      r_bit_idx  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_shift    <= w_data_masked;
        r_len      <= w_eff_len;
        r_par_en   <= parity;
        r_par_bit  <= w_par;
        r_stop2    <= stop_bits;
        r_bit_idx  <= '0;
        r_stop_cnt <= 1'b0;
      end else begin
        if (w_shift_en) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 4'd1;
        end
        if (w_stop_inc) begin
          r_stop_cnt <= 1'b1;
        end
      end
    end
  end

  assign tx       = r_tx;
  assign tx_ready = (r_state == IDLE);
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer
// Expected line levels come from a bit-list model of the frame format.
module tb_uart_tx_framer;

  logic       clk_16bd = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [8:0] tx_data;
  logic       parity;
  logic       parity_type;
  logic       stop_bits;
  logic [3:0] frame_length;
  logic       tx;
  logic       tx_ready;
  logic       tx_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] nx_d;
  logic       nx_p, nx_pt, nx_s2;
  logic [3:0] nx_fl;

  always #5 clk_16bd = ~clk_16bd;

  uart_tx_framer dut (
    .clk_16bd    (clk_16bd),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .parity      (parity),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .frame_length(frame_length),
    .tx          (tx),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [8:0] d, input logic p, input logic pt,
                             input logic s2, input logic [3:0] fl);
    tx_data      = d;
    parity       = p;
    parity_type  = pt;
    stop_bits    = s2;
    frame_length = fl;
    tx_start     = 1'b1;
  endtask

  // Called right after start_frame at a falling edge; checks every cycle of the frame.
  task automatic run_frame(input logic [8:0] d, input logic p, input logic pt,
                           input logic s2, input logic [3:0] fl,
                           input int mid, input bit chain);
    int   len;
    int   busy;
    logic pb;
    logic q[$];
    len = (fl >= 5 && fl <= 9) ? int'(fl) : 8;
    q.push_back(1'b0);
    for (int i = 0; i < len; i++) q.push_back(d[i]);
    if (p) begin
      pb = pt;
      for (int i = 0; i < len; i++) pb = pb ^ d[i];
      q.push_back(pb);
    end
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    busy = q.size() * 16;

    @(negedge clk_16bd);
    tx_start = 1'b0;
    for (int c = 0; c < busy; c++) begin
      chk("tx_bit", 32'(tx), 32'(q[c / 16]));
      chk("ready_busy", 32'(tx_ready), 32'd0);
      chk("done_busy", 32'(tx_done), 32'd0);
      if (c == mid) begin
        frame_length = 4'd5;
        parity       = ~parity;
        stop_bits    = ~stop_bits;
        tx_data      = 9'($urandom);
        tx_start     = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk_16bd);
    end
    chk("tx_end", 32'(tx), 32'd1);
    chk("ready_end", 32'(tx_ready), 32'd1);
    chk("done_end", 32'(tx_done), 32'd1);
    if (chain) begin
      start_frame(nx_d, nx_p, nx_pt, nx_s2, nx_fl);
    end else begin
      tx_start = 1'b0;
      @(negedge clk_16bd);
      chk("done_once", 32'(tx_done), 32'd0);
      chk("ready_idle", 32'(tx_ready), 32'd1);
      chk("tx_idle", 32'(tx), 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    logic       p, pt, s2;
    logic [3:0] fl;

    rst = 1'b1;
    start_frame(9'h000, 1'b0, 1'b0, 1'b0, 4'd8);
    tx_start = 1'b0;
    repeat (3) @(negedge clk_16bd);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    @(negedge clk_16bd);
    chk("idle_tx", 32'(tx), 32'd1);

    start_frame(9'h055, 1'b0, 1'b0, 1'b0, 4'd8);
    run_frame(9'h055, 1'b0, 1'b0, 1'b0, 4'd8, -1, 1'b0);

    start_frame(9'h003, 1'b1, 1'b0, 1'b0, 4'd7);
    run_frame(9'h003, 1'b1, 1'b0, 1'b0, 4'd7, -1, 1'b0);
    start_frame(9'h003, 1'b1, 1'b1, 1'b0, 4'd7);
    run_frame(9'h003, 1'b1, 1'b1, 1'b0, 4'd7, -1, 1'b0);

    start_frame(9'h1FF, 1'b1, 1'b1, 1'b1, 4'd9);
    run_frame(9'h1FF, 1'b1, 1'b1, 1'b1, 4'd9, -1, 1'b0);

    // Config churn and a stray start during data bit 2, then a back-to-back start on tx_done.
    nx_d = 9'h13C; nx_p = 1'b1; nx_pt = 1'b0; nx_s2 = 1'b0; nx_fl = 4'd6;
    start_frame(9'h0A5, 1'b0, 1'b0, 1'b0, 4'd8);
    run_frame(9'h0A5, 1'b0, 1'b0, 1'b0, 4'd8, 16 * 3 + 5, 1'b1);
    run_frame(9'h13C, 1'b1, 1'b0, 1'b0, 4'd6, -1, 1'b0);

    start_frame(9'h0C3, 1'b0, 1'b0, 1'b0, 4'b1111);
    run_frame(9'h0C3, 1'b0, 1'b0, 1'b0, 4'b1111, -1, 1'b0);
    start_frame(9'h15A, 1'b0, 1'b0, 1'b0, 4'b0010);
    run_frame(9'h15A, 1'b0, 1'b0, 1'b0, 4'b0010, -1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      d  = 9'($urandom);
      p  = 1'($urandom);
      pt = 1'($urandom);
      s2 = 1'($urandom);
      fl = 4'($urandom);
      start_frame(d, p, pt, s2, fl);
      run_frame(d, p, pt, s2, fl, -1, 1'b0);
    end

    // Reset at tick 7 of data bit 3 must abort cleanly with no tx_done.
    d = 9'h0F0;
    start_frame(d, 1'b0, 1'b0, 1'b0, 4'd8);
    @(negedge clk_16bd);
    tx_start = 1'b0;
    repeat (71) @(negedge clk_16bd);
    chk("pre_rst_bit3", 32'(tx), 32'(d[3]));
    rst = 1'b1;
    @(negedge clk_16bd);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_ready", 32'(tx_ready), 32'd1);
    chk("midrst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk_16bd);
      chk("postrst_done", 32'(tx_done), 32'd0);
      chk("postrst_tx", 32'(tx), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
